ifetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch.sv | 137 +++++++++++++
 tb/tb_ifetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction-fetch front end.
//   if_state_e : fetch FSM state encoding (IDLE/REQ/WAIT/HOLD, 2 bits)
//   PC_STEP    : byte distance between sequential instruction words
//   align_pc() : forces an address onto a word boundary
package ifetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_WAIT = 2'b10,
        IF_HOLD = 2'b11
    } if_state_e;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    // Clear the two byte-offset bits; masking keeps every input bit referenced.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction-fetch front end.
// Owns the architectural PC, issues one word read at a time to instruction
// memory (request/grant/response) and buffers the returned word for decode
// (valid/ready). A redirect squashes in-flight or buffered work and restarts
// fetch at the (word-aligned) target.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   redirect_valid   taken branch / jump this cycle (highest priority)
//   redirect_pc      redirect target, bits [1:0] ignored
//   imem_req         read request (decoded from state)
//   imem_addr        read address, always the PC register
//   imem_gnt         memory accepted the request (looked at only in REQ)
//   imem_rvalid      read data valid (looked at only in WAIT)
//   imem_rdata       instruction word
//   inst_valid       buffered instruction present (decoded from state)
//   inst_ready       decode accepts the instruction
//   inst, inst_pc    buffered instruction and its address
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    if_state_e   state_r,   state_s;
    logic [31:0] pc_r,      pc_s;
    logic        drop_r,    drop_s;
    logic [31:0] inst_r,    inst_s;
    logic [31:0] inst_pc_r, inst_pc_s;

    // Next-state, PC, drop flag and output-buffer logic; redirect overrides the PC last.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        drop_s    = drop_r;
        inst_s    = inst_r;
        inst_pc_s = inst_pc_r;

        case (state_r)
            IF_IDLE: begin
                state_s = IF_REQ;
            end
            IF_REQ: begin
                if (imem_gnt) begin
                    state_s = IF_WAIT;
                    // The old-address request is already accepted, so its
                    // response must be thrown away when we redirect now.
                    if (redirect_valid) begin
                        drop_s = 1'b1;
                    end else begin
                        drop_s = 1'b0;
                    end
                end else begin
                    state_s = IF_REQ;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid) begin
                    drop_s = 1'b0;
                    if (drop_r || redirect_valid) begin
                        state_s = IF_REQ;
                    end else begin
                        state_s   = IF_HOLD;
                        inst_s    = imem_rdata;
                        inst_pc_s = pc_r;
                        pc_s      = pc_r + PC_STEP;
                    end
                end else begin
                    state_s = IF_WAIT;
                    if (redirect_valid) begin
                        drop_s = 1'b1;
                    end else begin
                        drop_s = drop_r;
                    end
                end
            end
            IF_HOLD: begin
                // A redirect with inst_ready=1 still counts as a transfer;
                // decode squashes what it took in that cycle.
                if (inst_ready || redirect_valid) begin
                    state_s = IF_REQ;
                end else begin
                    state_s = IF_HOLD;
                end
            end
            default: begin
                state_s = IF_IDLE;
                drop_s  = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            pc_s = align_pc(redirect_pc);
        end else begin
            pc_s = pc_s;
        end
    end

    // State, PC, drop flag and instruction buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IF_IDLE;
            pc_r      <= align_pc(RESET_PC);
            drop_r    <= 1'b0;
            inst_r    <= 32'h0000_0000;
            inst_pc_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            drop_r    <= drop_s;
            inst_r    <= inst_s;
            inst_pc_r <= inst_pc_s;
        end
    end

    // Outputs come straight from registers or from the state register only.
    assign imem_req   = (state_r == IF_REQ);
    assign imem_addr  = pc_r;
    assign inst_valid = (state_r == IF_HOLD);
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    int n_pass = 0;
    int n_total = 0;

    // reference model: next instruction address of the fetch stream, memory responder
    logic [31:0] exp_pc;
    bit          outst;
    int          dly;
    logic [31:0] out_addr;

    // previous-cycle observations
    bit          prev_valid, prev_req, prev_gnt, prev_redir, prev_ready;
    logic [31:0] prev_addr, prev_inst, prev_inst_pc, redir_tgt;

    // stimulus knobs (percentages / max response delay)
    int p_redir, p_gnt, p_ready, max_dly;

    int          cyc = 0;
    int          deliveries = 0;
    logic [31:0] deliv_pcs[$];
    int          deliv_cyc[$];
    logic [31:0] saved_addr;
    logic [31:0] tmp_pc;
    logic [31:0] tmp_d0, tmp_d1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_pc     = RST_PC;
        outst      = 1'b0;
        dly        = 0;
        prev_valid = 1'b0;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
        prev_redir = 1'b0;
        prev_ready = 1'b0;
    endtask

    task automatic drive();
        redirect_valid = ($urandom_range(99) < p_redir);
        case ($urandom_range(3))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
            default: redirect_pc = $urandom_range(32'h0000_0FFF);
        endcase
        imem_gnt = ($urandom_range(99) < p_gnt);
        if (outst && dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(out_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (outst) dly--;
        end
        inst_ready = ($urandom_range(99) < p_ready);
    endtask

    task automatic check();
        chk("req_and_valid", {31'd0, imem_req & inst_valid}, 32'd0);
        chk("one_outstanding", {31'd0, imem_req & outst}, 32'd0);
        if (imem_req) chk("req_addr", imem_addr, exp_pc);
        if (prev_redir) begin
            chk("redir_addr", imem_addr, redir_tgt);
            chk("redir_req", {31'd0, imem_req}, {31'd0, !outst});
            chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        end
        if (prev_req && !prev_gnt && !prev_redir) begin
            chk("ungranted_req", {31'd0, imem_req}, 32'd1);
            chk("ungranted_addr", imem_addr, prev_addr);
        end
        if (prev_valid && !prev_ready && !prev_redir) begin
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, prev_inst);
            chk("hold_pc", inst_pc, prev_inst_pc);
        end
        if (prev_valid && (prev_ready || prev_redir))
            chk("hold_exit", {31'd0, inst_valid}, 32'd0);
        if (inst_valid && !prev_valid) begin
            chk("deliv_pc", inst_pc, exp_pc);
            chk("deliv_data", inst, memf(exp_pc));
            deliveries++;
            deliv_pcs.push_back(inst_pc);
            deliv_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) begin
            if (imem_rvalid) outst = 1'b0;
            if (imem_req && imem_gnt) begin
                outst    = 1'b1;
                out_addr = imem_addr;
                dly      = $urandom_range(max_dly);
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        prev_valid   = inst_valid;
        prev_req     = imem_req;
        prev_gnt     = imem_gnt;
        prev_redir   = redirect_valid;
        prev_ready   = inst_ready;
        prev_addr    = imem_addr;
        prev_inst    = inst;
        prev_inst_pc = inst_pc;
        redir_tgt    = redirect_pc & 32'hFFFF_FFFC;
        @(negedge clk);
        cyc++;
        check();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},     {31'd0, imem_req},   32'd0);
        chk({tag, "_addr"},    imem_addr,           RST_PC);
        chk({tag, "_valid"},   {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},    inst,                32'd0);
        chk({tag, "_inst_pc"}, inst_pc,             32'd0);
    endtask

    initial begin
        // reset state
        rstn = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // best case: gnt and ready always, response one cycle after grant
        p_redir = 0; p_gnt = 100; p_ready = 100; max_dly = 0;
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin drive(); tick(); end
        tmp_d0 = deliv_pcs.size() > 0 ? deliv_pcs[0] : 32'hX;
        chk("best_pc0", tmp_d0, 32'h0000_3000);
        tmp_d0 = deliv_pcs.size() > 1 ? deliv_pcs[1] : 32'hX;
        chk("best_pc1", tmp_d0, 32'h0000_3004);
        tmp_d0 = deliv_pcs.size() > 2 ? deliv_pcs[2] : 32'hX;
        chk("best_pc2", tmp_d0, 32'h0000_3008);
        tmp_d0 = deliv_cyc.size() > 1 ? deliv_cyc[1] - deliv_cyc[0] : 0;
        tmp_d1 = deliv_cyc.size() > 2 ? deliv_cyc[2] - deliv_cyc[1] : 0;
        chk("best_gap01", tmp_d0, 32'd3);
        chk("best_gap12", tmp_d1, 32'd3);

        // grant withheld for 4 cycles
        p_gnt = 0;
        for (int i = 0; i < 20 && !imem_req; i++) begin drive(); tick(); end
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        saved_addr = imem_addr;
        for (int i = 0; i < 4; i++) begin drive(); tick(); end
        chk("nognt_req", {31'd0, imem_req}, 32'd1);
        chk("nognt_addr", imem_addr, saved_addr);
        chk("nognt_valid", {31'd0, inst_valid}, 32'd0);

        // redirect in the grant cycle: the old response is discarded
        drive(); imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        chk("gntredir_req", {31'd0, imem_req}, 32'd0);
        p_gnt = 100; max_dly = 2;
        tmp_d0 = deliveries;
        for (int i = 0; i < 40 && deliveries == tmp_d0; i++) begin drive(); tick(); end
        tmp_d1 = deliv_pcs.size() > 0 ? deliv_pcs[$] : 32'hX;
        chk("gntredir_deliv", tmp_d1, 32'h0000_0040);

        // ready held low in HOLD, then redirect while holding
        p_ready = 0; max_dly = 0;
        for (int i = 0; i < 40 && !inst_valid; i++) begin drive(); tick(); end
        chk("wait_hold", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin drive(); tick(); end
        chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        drive(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        chk("holdredir_valid", {31'd0, inst_valid}, 32'd0);
        chk("holdredir_req", {31'd0, imem_req}, 32'd1);
        chk("holdredir_addr", imem_addr, 32'h0000_0080);

        // PC wraparound from the top word
        p_ready = 100; max_dly = 1;
        drive(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        tmp_d0 = deliveries;
        for (int i = 0; i < 40 && deliveries == tmp_d0; i++) begin drive(); tick(); end
        tmp_d1 = deliv_pcs.size() > 0 ? deliv_pcs[$] : 32'hX;
        chk("wrap_deliv", tmp_d1, 32'hFFFF_FFFC);
        for (int i = 0; i < 40 && !imem_req; i++) begin drive(); tick(); end
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // reset pulse while waiting for a response; late rvalid must be ignored
        max_dly = 0;
        for (int i = 0; i < 40 && !outst; i++) begin drive(); tick(); end
        chk("wait_grant", {31'd0, outst}, 32'd1);
        imem_rvalid = 1'b0;
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("midreset");
        reset_model();
        @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        drive(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        drive(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("late_req", {31'd0, imem_req}, 32'd1);
        chk("late_addr", imem_addr, RST_PC);
        tmp_d0 = deliveries;
        for (int i = 0; i < 40 && deliveries == tmp_d0; i++) begin drive(); tick(); end
        tmp_d1 = deliv_pcs.size() > 0 ? deliv_pcs[$] : 32'hX;
        chk("late_deliv", tmp_d1, RST_PC);

        // randomized traffic against the model
        p_redir = 8; p_gnt = 60; p_ready = 60; max_dly = 3;
        tmp_d0 = deliveries;
        for (int i = 0; i < 1500; i++) begin drive(); tick(); end
        chk("progress", {31'd0, (deliveries - tmp_d0) > 20}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
